adc_spi_capture: RTL and testbench

Parametrised SPI-style master for single-channel serial ADCs: conversion-start line, framed serial clock, MSB-first data capture.
Generalises the fixed 12-bit capture path: data width, divider, leading null bits, frame length and quiet time are all parameters; adds single-shot or continuous modes and a valid/ready sample output.
Sits between the ADC pins and downstream sample consumers (buffer/display logic).
Everything runs in the clk domain; sclk is a registered output, never used as a clock.

---
 rtl/adc_spi_capture.sv | 154 +++++++++++++++
 tb/tb_adc_spi_capture.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_capture.sv
// Serial ADC capture master: conv/sclk framing, MSB-first capture into a valid/ready sample port.
// Latency: sample_valid rises on the clk that ends the frame, CLK_DIV*(1+2*FRAME_BITS) clks after conv falls.
// Backpressure: none on the ADC side; an unaccepted sample is overwritten and overrun pulses. Optional: ADC_OVR_CNT_EN.
module adc_spi_capture #(
    parameter int DATA_W     = 12,
    parameter int CLK_DIV    = 16,
    parameter int LEAD_BITS  = 2,
    parameter int FRAME_BITS = 16,
    parameter int QUIET_CYC  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cont_en,
    input  logic              adc_miso,
    output logic              adc_sclk,
    output logic              adc_conv,
    output logic              busy,
    output logic [DATA_W-1:0] sample_data,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overrun
`ifdef ADC_OVR_CNT_EN
    ,
    output logic [7:0]        ovr_count
`endif
);

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int BIT_W  = $clog2(FRAME_BITS + 1);
    // Conv-high gap = one trailing sclk half-period (hold after the last
    // falling edge) plus QUIET_CYC clks; with the single IDLE clk this gives
    // a continuous frame period of CLK_DIV*(2+2*FRAME_BITS)+QUIET_CYC+1.
    localparam int Q_TOT  = CLK_DIV + QUIET_CYC;
    localparam int Q_W    = $clog2(Q_TOT + 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [Q_W-1:0]    q_cnt;
    logic [DATA_W-1:0] cap;
    logic              tick;
    logic              rise;
    logic              load;
    logic              in_window;

    assign tick      = (state != IDLE) && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign rise      = (state == SHIFT) && tick && !adc_sclk;
    assign load      = (state == SHIFT) && tick && adc_sclk && (bit_cnt == BIT_W'(FRAME_BITS));
    assign in_window = (int'(bit_cnt) >= LEAD_BITS) && (int'(bit_cnt) < LEAD_BITS + DATA_W);
    assign busy      = (state != IDLE);

    // Next-state decode: one tick of setup, 2*FRAME_BITS sclk half-periods, then quiet gap.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start || cont_en) state_nxt = SETUP;
            SETUP:   if (tick) state_nxt = SHIFT;
            SHIFT:   if (load) state_nxt = QUIET;
            QUIET:   if (q_cnt == Q_W'(Q_TOT - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; conv is registered from the next state so it tracks state exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            adc_conv <= 1'b1;
        end else begin
            state    <= state_nxt;
            adc_conv <= !((state_nxt == SETUP) || (state_nxt == SHIFT));
        end
    end

    // sclk half-period divider; held at zero in IDLE so every frame starts aligned.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (state == IDLE || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // sclk toggles on each tick while shifting (first toggle rising); low elsewhere.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            adc_sclk <= 1'b0;
        end else if (state == SHIFT) begin
            if (tick) adc_sclk <= ~adc_sclk;
        end else begin
            adc_sclk <= 1'b0;
        end
    end

    // Rising-edge bit index and MSB-first capture of the data window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt <= '0;
            cap     <= '0;
        end else if (state != SHIFT) begin
            bit_cnt <= '0;
        end else if (rise) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (in_window) cap <= {cap[DATA_W-2:0], adc_miso};
        end
    end

    // Quiet-gap timer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_cnt <= '0;
        end else if (state == QUIET) begin
            q_cnt <= q_cnt + 1'b1;
        end else begin
            q_cnt <= '0;
        end
    end

    // Sample port: load at frame end wins over a simultaneous handshake; overwrite of an unaccepted sample flags overrun.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_data  <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (load) begin
                sample_data  <= cap;
                sample_valid <= 1'b1;
                overrun      <= sample_valid && !sample_ready;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end

`ifdef ADC_OVR_CNT_EN
    // Saturating overrun event counter, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovr_count <= '0;
        end else if (overrun && (ovr_count != 8'hFF)) begin
            ovr_count <= ovr_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_adc_spi_capture.sv
// Bench for adc_spi_capture: ADC pin model, sample scoreboard, framing timing checks.
// Runs single-shot, continuous, overrun, mid-frame reset, ignored start and same-clk load/accept cases.
// Overrun counter saturation is exercised only when ADC_OVR_CNT_EN is defined.
module tb_adc_spi_capture;

    localparam int DATA_W     = 12;
    localparam int CLK_DIV    = 4;
    localparam int LEAD_BITS  = 2;
    localparam int FRAME_BITS = 16;
    localparam int QUIET_CYC  = 8;
    localparam int CLK_PER    = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              cont_en;
    logic              adc_miso;
    logic              adc_sclk;
    logic              adc_conv;
    logic              busy;
    logic [DATA_W-1:0] sample_data;
    logic              sample_valid;
    logic              sample_ready;
    logic              overrun;
`ifdef ADC_OVR_CNT_EN
    logic [7:0]        ovr_count;
`endif

    adc_spi_capture #(
        .DATA_W    (DATA_W),
        .CLK_DIV   (CLK_DIV),
        .LEAD_BITS (LEAD_BITS),
        .FRAME_BITS(FRAME_BITS),
        .QUIET_CYC (QUIET_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cont_en     (cont_en),
        .adc_miso    (adc_miso),
        .adc_sclk    (adc_sclk),
        .adc_conv    (adc_conv),
        .busy        (busy),
        .sample_data (sample_data),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .overrun     (overrun)
`ifdef ADC_OVR_CNT_EN
        ,
        .ovr_count   (ovr_count)
`endif
    );

    always #(CLK_PER / 2) clk = ~clk;

    int              n_tests = 0;
    int              n_fail  = 0;
    logic [11:0]     adc_words[$];
    logic [11:0]     exp_q[$];
    logic [15:0]     frame_bits = '0;
    int              bit_idx = 0;
    int              rises = 0;
    int              n_frames = 0;
    int              ovr_seen = 0;
    longint unsigned t_fall = 0;
    bit              have_fall = 1'b0;
    int              low_len = 0;
    int              last_period = 0;
    bit              mon_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ADC model: lead bits 01, 12-bit word, trailing 11; bit k valid before sclk rise k.
    always @(negedge adc_conv) begin
        logic [11:0] w;
        w = 12'h000;
        if (adc_words.size() > 0) w = adc_words.pop_front();
        frame_bits = {2'b01, w, 2'b11};
        bit_idx    = 0;
        adc_miso   = frame_bits[15];
        n_frames++;
        if (have_fall) last_period = int'(($time - t_fall) / CLK_PER);
        t_fall    = $time;
        have_fall = 1'b1;
    end

    always @(negedge adc_sclk) begin
        if (!adc_conv && bit_idx < 15) begin
            bit_idx++;
            adc_miso = frame_bits[15 - bit_idx];
        end
    end

    always @(posedge adc_sclk) rises++;

    always @(posedge adc_conv) begin
        if (have_fall) low_len = int'(($time - t_fall) / CLK_PER);
    end

    // Scoreboard consumer: a handshake is due at the next posedge.
    always @(negedge clk) begin
        logic [11:0] e;
        if (overrun === 1'b1) ovr_seen++;
        if (mon_en && sample_valid === 1'b1 && sample_ready === 1'b1) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_data", 32'(sample_data), 32'(e));
            end else begin
                check("sb_unexpected", 32'(sample_valid), 0);
            end
        end
    end

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        tick_n(1);
        start = 1'b1;
        tick_n(1);
        start = 1'b0;
    endtask

    task automatic accept_one();
        tick_n(1);
        sample_ready = 1'b1;
        tick_n(1);
        sample_ready = 1'b0;
    endtask

    task automatic wait_valid(input int max);
        int i = 0;
        while (sample_valid !== 1'b1 && i < max) begin
            @(negedge clk);
            i++;
        end
        check("wait_valid", 32'(sample_valid), 1);
    endtask

    task automatic wait_idle(input int max);
        int i = 0;
        while (busy !== 1'b0 && i < max) begin
            @(negedge clk);
            i++;
        end
        check("wait_idle", 32'(busy), 0);
    endtask

    task automatic wait_conv_low(input int max);
        int i = 0;
        while (adc_conv !== 1'b0 && i < max) begin
            @(negedge clk);
            i++;
        end
        check("wait_conv_low", 32'(adc_conv), 0);
    endtask

    task automatic wait_rises(input int target, input int max);
        int i = 0;
        while (rises < target && i < max) begin
            @(negedge clk);
            i++;
        end
        check("wait_rises", 32'(rises), 32'(target));
    endtask

    initial begin
        #(CLK_PER * 90000);
        $display("FAIL watchdog: time limit reached, got no summary, expected summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int          base_ovr;
        int          base_rise;
        int          base_frm;
        int          i;
        logic [11:0] e;

        reset        = 1'b1;
        start        = 1'b0;
        cont_en      = 1'b0;
        sample_ready = 1'b0;
        adc_miso     = 1'b0;
        #2;
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_conv", 32'(adc_conv), 1);
        check("rst_sclk", 32'(adc_sclk), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(sample_valid), 0);
        check("rst_data", 32'(sample_data), 0);
        check("rst_overrun", 32'(overrun), 0);
`ifdef ADC_OVR_CNT_EN
        check("rst_ovr_count", 32'(ovr_count), 0);
`endif
        tick_n(1);
        reset = 1'b1;
        tick_n(2);

        // 1: single shot
        adc_words.push_back(12'hA5C);
        exp_q.push_back(12'hA5C);
        base_rise = rises;
        pulse_start();
        wait_valid(400);
        e = exp_q.pop_front();
        check("t1_data", 32'(sample_data), 32'(e));
        check("t1_conv_low", 32'(low_len), 132);
        check("t1_rises", 32'(rises - base_rise), 16);
        wait_idle(100);
        accept_one();
        @(negedge clk);
        check("t1_accepted", 32'(sample_valid), 0);

        // 2: continuous with ready held high
        base_ovr = ovr_seen;
        base_frm = n_frames;
        mon_en   = 1'b1;
        tick_n(1);
        sample_ready = 1'b1;
        adc_words.push_back(12'h001); exp_q.push_back(12'h001);
        adc_words.push_back(12'hFFF); exp_q.push_back(12'hFFF);
        adc_words.push_back(12'h800); exp_q.push_back(12'h800);
        cont_en = 1'b1;
        i = 0;
        while (exp_q.size() > 1 && i < 600) begin
            @(negedge clk);
            i++;
        end
        check("t2_two_popped", 32'(exp_q.size()), 1);
        wait_conv_low(50);
        tick_n(1);
        cont_en = 1'b0;
        i = 0;
        while (exp_q.size() > 0 && i < 300) begin
            @(negedge clk);
            i++;
        end
        check("t2_drained", 32'(exp_q.size()), 0);
        wait_idle(50);
        check("t2_period", 32'(last_period), 145);
        tick_n(200);
        check("t2_stays_idle", 32'(busy), 0);
        check("t2_frames", 32'(n_frames - base_frm), 3);
        check("t2_no_overrun", 32'(ovr_seen - base_ovr), 0);
        mon_en       = 1'b0;
        sample_ready = 1'b0;

        // 3: two frames, nobody accepts
        base_ovr = ovr_seen;
        adc_words.push_back(12'h3C3);
        adc_words.push_back(12'h5A5);
        exp_q.push_back(12'h5A5);
        tick_n(1);
        cont_en = 1'b1;
        wait_valid(400);
        wait_conv_low(50);
        tick_n(1);
        cont_en = 1'b0;
        wait_idle(400);
        tick_n(2);
        check("t3_overrun_once", 32'(ovr_seen - base_ovr), 1);
        e = exp_q.pop_front();
        check("t3_data", 32'(sample_data), 32'(e));
        check("t3_valid", 32'(sample_valid), 1);
`ifdef ADC_OVR_CNT_EN
        check("t3_ovr_count", 32'(ovr_count), 1);
`endif
        accept_one();
        @(negedge clk);
        check("t3_accepted", 32'(sample_valid), 0);

        // 4: reset at rising edge 7 of a frame
        adc_words.push_back(12'h123);
        base_rise = rises;
        pulse_start();
        wait_rises(base_rise + 7, 300);
        reset = 1'b0;
        #1;
        check("t4_conv", 32'(adc_conv), 1);
        check("t4_sclk", 32'(adc_sclk), 0);
        check("t4_busy", 32'(busy), 0);
        check("t4_valid", 32'(sample_valid), 0);
`ifdef ADC_OVR_CNT_EN
        check("t4_ovr_count", 32'(ovr_count), 0);
`endif
        tick_n(2);
        reset = 1'b1;
        tick_n(300);
        check("t4_no_sample", 32'(sample_valid), 0);
        check("t4_idle", 32'(busy), 0);

        // 5a: start during SHIFT is ignored
        base_frm = n_frames;
        base_ovr = ovr_seen;
        adc_words.push_back(12'h2D4);
        exp_q.push_back(12'h2D4);
        base_rise = rises;
        pulse_start();
        wait_rises(base_rise + 3, 300);
        pulse_start();
        wait_valid(400);
        wait_idle(100);
        tick_n(200);
        check("t5_one_frame", 32'(n_frames - base_frm), 1);
        e = exp_q.pop_front();
        check("t5_data", 32'(sample_data), 32'(e));

        // 5b: accept the old sample in the same clk the new one loads
        adc_words.push_back(12'h6B1);
        exp_q.push_back(12'h6B1);
        base_rise = rises;
        pulse_start();
        wait_rises(base_rise + 16, 400);
        repeat (3) @(posedge clk);
        #1;
        sample_ready = 1'b1;
        @(posedge clk);
        #1;
        sample_ready = 1'b0;
        @(negedge clk);
        check("t5_load_valid", 32'(sample_valid), 1);
        e = exp_q.pop_front();
        check("t5_load_data", 32'(sample_data), 32'(e));
        check("t5_load_sclk", 32'(adc_sclk), 0);
        tick_n(5);
        check("t5_no_overrun", 32'(ovr_seen - base_ovr), 0);
        wait_idle(100);
        accept_one();

`ifdef ADC_OVR_CNT_EN
        // 6: counter saturation over 260 overruns
        base_ovr = ovr_seen;
        tick_n(1);
        cont_en = 1'b1;
        i = 0;
        while ((ovr_seen - base_ovr) < 260 && i < 40000) begin
            @(negedge clk);
            i++;
        end
        tick_n(1);
        cont_en = 1'b0;
        wait_idle(400);
        check("t6_overruns", 32'(ovr_seen - base_ovr), 260);
        check("t6_ovr_count_sat", 32'(ovr_count), 255);
        accept_one();
`endif

        tick_n(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
